// File: rtl/aes_ctr_pkg.sv
// Shared types and widths for the AES-256 CTR stream front end.
package aes_ctr_pkg;
  localparam int AES_BLK_W    = 128;
  localparam int AES256_KEY_W = 256;

  typedef enum logic [2:0] {
    ST_UNCFG, ST_KEY_CMD, ST_KEY_WAIT, ST_CTR_CMD,
    ST_CTR_WAIT, ST_GEN_CMD, ST_GEN_WAIT, ST_READY
  } ctr_state_e;

  function automatic logic is_wait(ctr_state_e s);
    return (s == ST_KEY_WAIT) || (s == ST_CTR_WAIT) || (s == ST_GEN_WAIT);
  endfunction
endpackage

// File: rtl/aes256_ctr_xor_stage.sv
// One-block keystream buffer, XOR and valid/ready output register.
module aes256_ctr_xor_stage
  import aes_ctr_pkg::*;
#(
  parameter int DATA_W = AES_BLK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ks_load,
  input  logic [DATA_W-1:0] ks_din,
  input  logic              ks_clr,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ks_valid
);
  logic [DATA_W-1:0] ks_buf_q, ks_buf_d, out_data_q, out_data_d;
  logic              ks_valid_q, ks_valid_d, out_valid_q, out_valid_d;
  logic              accept;

  assign in_ready  = ks_valid_q & ~hold & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ks_valid  = ks_valid_q;

  always_comb begin
    ks_buf_d    = ks_buf_q;
    ks_valid_d  = ks_valid_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (ks_load) begin
      ks_buf_d   = ks_din;
      ks_valid_d = 1'b1;
    end
    // each keystream block is used exactly once
    if (accept) ks_valid_d = 1'b0;
    if (ks_clr) ks_valid_d = 1'b0;
    if (accept) begin
      out_data_d  = in_data ^ ks_buf_q;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_buf_q    <= '0;
      ks_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ks_buf_q    <= ks_buf_d;
      ks_valid_q  <= ks_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: rtl/aes256_ctr_stream.sv
// Command sequencer for an aes256_ctr core plus CTR crypt datapath.
module aes256_ctr_stream
  import aes_ctr_pkg::*;
#(
  parameter int DATA_W    = AES_BLK_W,
  parameter int KEY_W     = AES256_KEY_W,
  parameter int TIMEOUT_W = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CFG_LOAD,
  input  logic [KEY_W-1:0]  CFG_KEY,
  input  logic [DATA_W-1:0] CFG_IV,
  output logic              CFG_BUSY,
  output logic              ERR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              CORE_SET_KEY,
  output logic              CORE_SET_COUNT,
  output logic              CORE_START_ENC,
  output logic [KEY_W-1:0]  CORE_KEY,
  output logic [DATA_W-1:0] CORE_DATA,
  input  logic              CORE_BUSY,
  input  logic [DATA_W-1:0] CORE_DOUT
);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  ctr_state_e         state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]  iv_q, iv_d;
  logic               pend_q, pend_d, err_q, err_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic               in_wait, wait_done, wd_exp, ks_load, ks_clr, ks_valid;

  assign in_wait   = is_wait(state_q);
  // wd_q is 0 in the first wait cycle, so a nonzero count enforces the 2-cycle gap
  assign wait_done = in_wait & (|wd_q) & ~CORE_BUSY;
  assign wd_exp    = in_wait & ~wait_done & (wd_q == WD_LAST);

  assign CFG_BUSY  = (state_q == ST_KEY_CMD) || (state_q == ST_KEY_WAIT) ||
                     (state_q == ST_CTR_CMD) || (state_q == ST_CTR_WAIT);
  assign ERR       = err_q;
  assign CORE_KEY  = key_q;
  assign CORE_DATA = iv_q;

  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    iv_d           = iv_q;
    pend_d         = pend_q;
    err_d          = err_q;
    wd_d           = in_wait ? wd_q + 1'b1 : '0;
    ks_load        = 1'b0;
    ks_clr         = 1'b0;
    CORE_SET_KEY   = 1'b0;
    CORE_SET_COUNT = 1'b0;
    CORE_START_ENC = 1'b0;
    case (state_q)
      ST_KEY_CMD: if (!CORE_BUSY) begin CORE_SET_KEY = 1'b1; state_d = ST_KEY_WAIT; end
      ST_KEY_WAIT: if (wait_done) state_d = pend_q ? ST_KEY_CMD : ST_CTR_CMD;
      ST_CTR_CMD: if (!CORE_BUSY) begin CORE_SET_COUNT = 1'b1; state_d = ST_CTR_WAIT; end
      ST_CTR_WAIT: if (wait_done) state_d = pend_q ? ST_KEY_CMD : ST_GEN_CMD;
      ST_GEN_CMD: if (!CORE_BUSY) begin CORE_START_ENC = 1'b1; state_d = ST_GEN_WAIT; end
      ST_GEN_WAIT: begin
        if (wait_done) begin
          if (pend_q) state_d = ST_KEY_CMD;
          else begin ks_load = 1'b1; state_d = ST_READY; end
        end
      end
      ST_READY: begin
        if (pend_q) state_d = ST_KEY_CMD;
        else if (!ks_valid) state_d = ST_GEN_CMD;
      end
      default: ;
    endcase
    if (state_d == ST_KEY_CMD && state_q != ST_KEY_CMD) pend_d = 1'b0;

    if (wd_exp) begin
      err_d   = 1'b1;
      ks_clr  = 1'b1;
      pend_d  = 1'b0;
      state_d = ST_UNCFG;
    end else if (CFG_LOAD) begin
      key_d  = CFG_KEY;
      iv_d   = CFG_IV;
      err_d  = 1'b0;
      ks_clr = 1'b1;
      // mid-command loads are deferred until the core is idle again
      if (state_q == ST_UNCFG || state_q == ST_READY) begin
        state_d = ST_KEY_CMD;
        pend_d  = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_UNCFG;
      key_q   <= '0;
      iv_q    <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      iv_q    <= iv_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  aes256_ctr_xor_stage #(.DATA_W(DATA_W)) u_xor (
    .clk       (CLK),
    .rst_n     (RST_N),
    .ks_load   (ks_load),
    .ks_din    (CORE_DOUT),
    .ks_clr    (ks_clr),
    .hold      (pend_q),
    .in_valid  (IN_VALID),
    .in_ready  (IN_READY),
    .in_data   (IN_DATA),
    .out_valid (OUT_VALID),
    .out_ready (OUT_READY),
    .out_data  (OUT_DATA),
    .ks_valid  (ks_valid)
  );
endmodule

// File: tb/tb_aes256_ctr_stream.sv
// Directed bench for aes256_ctr_stream with a behavioural stand-in for the aes256_ctr core.
module tb_aes256_ctr_stream;
  import aes_ctr_pkg::*;

  localparam logic [255:0] NKEY  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] NIV   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] NIV2  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] KS1   = 128'h0bdf7df1591716335e9a8b15c860c502;
  localparam logic [127:0] KS2   = 128'h5a6e699d536119065433863c8f657b94;
  localparam logic [127:0] PT1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT1   = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] PT2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT2   = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
  // stand-in keystream off the NIST table is ctr ^ key[127:0]
  localparam logic [127:0] WRAP1 = 128'he0cad3f8c49ef728d267ef5cf6eb200b;
  localparam logic [127:0] WRAP2 = 128'h1f352c073b6108d72d9810a30914dff4;

  logic CLK, RST_N, CFG_LOAD, CFG_BUSY, ERR, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [255:0] CFG_KEY, CORE_KEY;
  logic [127:0] CFG_IV, IN_DATA, OUT_DATA, CORE_DATA, CORE_DOUT;
  logic CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC, CORE_BUSY;

  int vecs = 0, errs = 0;
  bit hang = 0;
  int start_cnt, proto_err;

  aes256_ctr_stream dut (
    .CLK(CLK), .RST_N(RST_N), .CFG_LOAD(CFG_LOAD), .CFG_KEY(CFG_KEY), .CFG_IV(CFG_IV),
    .CFG_BUSY(CFG_BUSY), .ERR(ERR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .CORE_SET_KEY(CORE_SET_KEY), .CORE_SET_COUNT(CORE_SET_COUNT),
    .CORE_START_ENC(CORE_START_ENC), .CORE_KEY(CORE_KEY), .CORE_DATA(CORE_DATA),
    .CORE_BUSY(CORE_BUSY), .CORE_DOUT(CORE_DOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [127:0] ks_fn(input logic [255:0] k, input logic [127:0] c);
    if (k == NKEY && c == NIV)  return KS1;
    if (k == NKEY && c == NIV2) return KS2;
    return c ^ k[127:0];
  endfunction

  // core model: busy for 3 cycles after any command, self-incrementing counter
  logic [255:0] m_key;
  logic [127:0] m_ctr;
  logic [1:0]   m_cnt;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CORE_BUSY <= 1'b0; CORE_DOUT <= '0; m_key <= '0; m_ctr <= '0; m_cnt <= '0;
      start_cnt <= 0; proto_err <= 0;
    end else begin
      if (CORE_BUSY && !hang) begin
        if (m_cnt == 2'd0) CORE_BUSY <= 1'b0;
        else m_cnt <= m_cnt - 2'd1;
      end
      if (CORE_SET_KEY | CORE_SET_COUNT | CORE_START_ENC) begin
        if (CORE_BUSY || $countones({CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC}) > 1)
          proto_err <= proto_err + 1;
        CORE_BUSY <= 1'b1;
        m_cnt     <= 2'd2;
        if (CORE_SET_KEY)   m_key <= CORE_KEY;
        if (CORE_SET_COUNT) m_ctr <= CORE_DATA;
        if (CORE_START_ENC) begin
          CORE_DOUT <= ks_fn(m_key, m_ctr);
          m_ctr     <= m_ctr + 128'd1;
          start_cnt <= start_cnt + 1;
        end
      end
    end
  end

  task automatic cfg(input logic [255:0] k, input logic [127:0] iv, output logic busy_seen);
    @(negedge CLK); CFG_LOAD = 1'b1; CFG_KEY = k; CFG_IV = iv;
    @(negedge CLK); CFG_LOAD = 1'b0; busy_seen = CFG_BUSY;
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (IN_READY) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (CORE_START_ENC) begin ok = 1'b1; break; end
    end
  endtask

  // push one block; returns OUT_* sampled just after the accepting edge
  task automatic xfer(input logic [127:0] din, output logic [127:0] got, output bit ok);
    ok = 1'b0; got = '0;
    @(negedge CLK); IN_VALID = 1'b1; IN_DATA = din;
    for (int i = 0; i < 300; i++) begin
      if (IN_READY) begin
        @(posedge CLK); #1;
        IN_VALID = 1'b0; got = OUT_DATA; ok = OUT_VALID;
        break;
      end
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; CFG_LOAD = 1'b0; CFG_KEY = '0; CFG_IV = '0;
    IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b1;
    #12;
    vecs++;
    if ({OUT_VALID, IN_READY, CFG_BUSY, ERR, CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC, OUT_DATA} !== '0) begin
      errs++; $display("FAIL reset_outputs: ov=%b ir=%b cb=%b err=%b cmd=%b%b%b data=%h, want all 0",
        OUT_VALID, IN_READY, CFG_BUSY, ERR, CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC, OUT_DATA);
    end
    @(negedge CLK); RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    vecs++;
    if ({IN_READY, CFG_BUSY, CORE_SET_KEY} !== 3'b000) begin
      errs++; $display("FAIL uncfg_idle: ir=%b cb=%b set_key=%b, want 000", IN_READY, CFG_BUSY, CORE_SET_KEY);
    end
  endtask

  task automatic test_encrypt;
    logic b; logic [127:0] got; bit ok;
    cfg(NKEY, NIV, b);
    vecs++;
    if (b !== 1'b1 || CORE_KEY !== NKEY) begin
      errs++; $display("FAIL cfg_busy_key: cfg_busy=%b key=%h, want 1 / %h", b, CORE_KEY, NKEY);
    end
    xfer(PT1, got, ok);
    vecs++;
    if (!ok || got !== CT1) begin errs++; $display("FAIL enc_blk1: valid=%0b data=%h, want 1 %h", ok, got, CT1); end
    xfer(PT2, got, ok);
    vecs++;
    if (!ok || got !== CT2) begin errs++; $display("FAIL enc_blk2: valid=%0b data=%h, want 1 %h", ok, got, CT2); end
    @(posedge CLK); #1;
    vecs++;
    if (OUT_VALID !== 1'b0) begin errs++; $display("FAIL out_drop: out_valid=%b, want 0", OUT_VALID); end
  endtask

  task automatic test_decrypt;
    logic b; logic [127:0] got; bit ok;
    cfg(NKEY, NIV, b);
    xfer(CT1, got, ok);
    vecs++;
    if (!ok || got !== PT1) begin errs++; $display("FAIL dec_blk1: valid=%0b data=%h, want 1 %h", ok, got, PT1); end
    xfer(CT2, got, ok);
    vecs++;
    if (!ok || got !== PT2) begin errs++; $display("FAIL dec_blk2: valid=%0b data=%h, want 1 %h", ok, got, PT2); end
  endtask

  task automatic test_backpressure;
    logic b; logic [127:0] got; bit ok; int s0, bad;
    cfg(NKEY, NIV, b);
    wait_rdy(ok);
    s0 = start_cnt;
    OUT_READY = 1'b0;
    xfer(PT1, got, ok);
    vecs++;
    if (!ok || got !== CT1) begin errs++; $display("FAIL bp_blk1: valid=%0b data=%h, want 1 %h", ok, got, CT1); end
    @(negedge CLK); IN_VALID = 1'b1; IN_DATA = PT2;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      vecs++;
      if ({OUT_VALID, IN_READY} !== 2'b10 || OUT_DATA !== CT1) begin
        errs++; bad++;
        if (bad <= 3) $display("FAIL bp_hold cyc %0d: ov=%b ir=%b data=%h, want 1 0 %h", i, OUT_VALID, IN_READY, OUT_DATA, CT1);
      end
    end
    vecs++;
    if (start_cnt - s0 !== 1) begin errs++; $display("FAIL bp_start_count: %0d START_ENC, want 1", start_cnt - s0); end
    OUT_READY = 1'b1;
    #1;
    vecs++;
    if (IN_READY !== 1'b1) begin errs++; $display("FAIL bp_release_ready: in_ready=%b, want 1", IN_READY); end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    vecs++;
    if (OUT_VALID !== 1'b1 || OUT_DATA !== CT2) begin
      errs++; $display("FAIL bp_blk2: valid=%b data=%h, want 1 %h", OUT_VALID, OUT_DATA, CT2);
    end
  endtask

  task automatic test_cfg_during_gen;
    logic b; logic [127:0] got; bit ok;
    wait_rdy(ok);
    cfg(NKEY, 128'h0, b);
    wait_start(ok);
    @(negedge CLK);
    vecs++;
    if (!ok || dut.state_q !== ST_GEN_WAIT) begin
      errs++; $display("FAIL gen_wait_reached: start_seen=%0b state=%0d, want 1 %0d", ok, dut.state_q, ST_GEN_WAIT);
    end
    CFG_LOAD = 1'b1; CFG_KEY = NKEY; CFG_IV = NIV;
    @(negedge CLK); CFG_LOAD = 1'b0;
    vecs++;
    if (IN_READY !== 1'b0) begin errs++; $display("FAIL pend_ready: in_ready=%b, want 0", IN_READY); end
    xfer(PT1, got, ok);
    vecs++;
    if (!ok || got !== CT1) begin errs++; $display("FAIL reconfig_blk1: valid=%0b data=%h, want 1 %h", ok, got, CT1); end
  endtask

  task automatic test_wrap;
    logic b; logic [127:0] got; bit ok;
    cfg(NKEY, {128{1'b1}}, b);
    xfer(128'h0, got, ok);
    vecs++;
    if (!ok || got !== WRAP1) begin errs++; $display("FAIL wrap_blk1: valid=%0b data=%h, want 1 %h", ok, got, WRAP1); end
    xfer(128'h0, got, ok);
    vecs++;
    if (!ok || got !== WRAP2) begin errs++; $display("FAIL wrap_blk2: valid=%0b data=%h, want 1 %h", ok, got, WRAP2); end
  endtask

  task automatic test_watchdog;
    logic b; logic [127:0] got; bit ok;
    wait_rdy(ok);
    hang = 1'b1;
    cfg(NKEY, NIV, b);
    repeat (1010) @(negedge CLK);
    vecs++;
    if (ERR !== 1'b0) begin errs++; $display("FAIL wd_early: err=%b after 1010 cycles, want 0", ERR); end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (ERR === 1'b1) begin ok = 1'b1; break; end
    end
    vecs++;
    if (!ok) begin errs++; $display("FAIL wd_expire: err=%b after 1070 cycles, want 1", ERR); end
    vecs++;
    if ({IN_READY, CFG_BUSY} !== 2'b00 || dut.state_q !== ST_UNCFG) begin
      errs++; $display("FAIL wd_state: ir=%b cb=%b state=%0d, want 0 0 %0d", IN_READY, CFG_BUSY, dut.state_q, ST_UNCFG);
    end
    hang = 1'b0;
    repeat (8) @(negedge CLK);
    cfg(NKEY, NIV, b);
    vecs++;
    if (ERR !== 1'b0) begin errs++; $display("FAIL wd_err_clear: err=%b, want 0", ERR); end
    xfer(PT1, got, ok);
    vecs++;
    if (!ok || got !== CT1) begin errs++; $display("FAIL wd_recover: valid=%0b data=%h, want 1 %h", ok, got, CT1); end
  endtask

  task automatic test_async_reset;
    logic [127:0] got; bit ok;
    wait_rdy(ok);
    OUT_READY = 1'b0;
    xfer(PT2, got, ok);
    vecs++;
    if (!ok || got !== CT2) begin errs++; $display("FAIL ar_blk: valid=%0b data=%h, want 1 %h", ok, got, CT2); end
    wait_start(ok);
    @(negedge CLK);
    vecs++;
    if (!ok || dut.state_q !== ST_GEN_WAIT) begin
      errs++; $display("FAIL ar_gen_wait: start_seen=%0b state=%0d, want 1 %0d", ok, dut.state_q, ST_GEN_WAIT);
    end
    #2 RST_N = 1'b0;
    #1;
    vecs++;
    if ({OUT_VALID, IN_READY, CFG_BUSY, ERR, CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC, OUT_DATA} !== '0) begin
      errs++; $display("FAIL async_reset: ov=%b ir=%b cb=%b err=%b cmd=%b%b%b data=%h, want all 0",
        OUT_VALID, IN_READY, CFG_BUSY, ERR, CORE_SET_KEY, CORE_SET_COUNT, CORE_START_ENC, OUT_DATA);
    end
    @(negedge CLK); RST_N = 1'b1; OUT_READY = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_protocol;
    vecs++;
    if (proto_err !== 0) begin errs++; $display("FAIL core_protocol: %0d command violations, want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_cfg_during_gen();
    test_wrap();
    test_watchdog();
    test_protocol();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish by 500000, want finish");
    $fatal(1);
  end
endmodule
